// File: rtl/neg_exp_core.sv
// neg_exp_core: bit-serial e^-x evaluator.
// x is unsigned Q4.12; the result is built as a product of precomputed
// factors e^-(2^(k-12)), one per set bit of x, processed MSB first over
// 16 cycles. The accumulator is Q1.31 and the result is its top 16 bits
// (Q1.15, 0x8000 = 1.0).
module neg_exp_core (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [15:0] x_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] y_out
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [31:0] ONE_Q31 = 32'h8000_0000;

  state_t      state_r, state_s;
  logic [15:0] x_r,     x_s;
  logic [31:0] acc_r,   acc_s;
  logic [3:0]  cnt_r,   cnt_s;
  logic        done_r,  done_s;
  logic [15:0] y_r,     y_s;

  logic [31:0] coef_s;
  logic [63:0] prod_s;
  logic [31:0] mul_s;

  // floor(e^-(2^(k-12)) * 2^31); every entry is below 2^31, so the
  // accumulator can only shrink and never needs saturation.
  function automatic logic [31:0] exp_coef(input logic [3:0] k);
    logic [31:0] c;
    case (k)
      4'd15:   c = 32'h000A_FE10; // e^-8
      4'd14:   c = 32'h0258_2AB7; // e^-4
      4'd13:   c = 32'h1152_AAA3; // e^-2
      4'd12:   c = 32'h2F16_AC6C; // e^-1
      4'd11:   c = 32'h4DA2_CBF2; // e^-1/2
      4'd10:   c = 32'h63AF_BE7A; // e^-1/4
      4'd9:    c = 32'h70F5_A893; // e^-1/8
      4'd8:    c = 32'h783E_AFEF; // e^-1/16
      4'd7:    c = 32'h7C0F_D5AA; // e^-1/32
      4'd6:    c = 32'h7E03_FAAF; // e^-1/64
      4'd5:    c = 32'h7F00_FF55; // e^-1/128
      4'd4:    c = 32'h7F80_3FEA; // e^-1/256
      4'd3:    c = 32'h7FC0_0FFD; // e^-1/512
      4'd2:    c = 32'h7FE0_03FF; // e^-1/1024
      4'd1:    c = 32'h7FF0_00FF; // e^-1/2048
      4'd0:    c = 32'h7FF8_003F; // e^-1/4096
      default: c = ONE_Q31;
    endcase
    return c;
  endfunction

  // Q1.31 x Q1.31 multiply of the accumulator by the factor for the current bit;
  // the 64-bit product is shifted back by 31 and truncated (no rounding).
  always_comb begin
    coef_s = exp_coef(cnt_r);
    prod_s = {32'h0000_0000, acc_r} * {32'h0000_0000, coef_s};
    mul_s  = 32'(prod_s >> 31);
  end

  // Next-state and datapath update for the IDLE/RUN controller.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    y_s     = y_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          x_s     = x_in;
          acc_s   = ONE_Q31;
          cnt_s   = 4'd15;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (x_r[cnt_r]) begin
          acc_s = mul_s;
        end else begin
          acc_s = acc_r;
        end
        cnt_s = cnt_r - 4'd1;
        // Last bit: publish the result and drop back to IDLE so a new
        // start can be taken in the very cycle done is visible.
        if (cnt_r == 4'd0) begin
          state_s = IDLE;
          done_s  = 1'b1;
          y_s     = acc_s[31:16];
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any computation in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
      x_r     <= 16'h0000;
      acc_r   <= ONE_Q31;
      cnt_r   <= 4'd15;
      done_r  <= 1'b0;
      y_r     <= 16'h0000;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      done_r  <= done_s;
      y_r     <= y_s;
    end
  end

  assign busy  = (state_r == RUN);
  assign done  = done_r;
  assign y_out = y_r;

endmodule

// File: tb/tb_neg_exp_core.sv
// Directed bench for neg_exp_core with an expected-result scoreboard.
module tb_neg_exp_core;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start;
  logic [15:0] x_in;
  logic        busy;
  logic        done;
  logic [15:0] y_out;

  neg_exp_core dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .start   (start),
    .x_in    (x_in),
    .busy    (busy),
    .done    (done),
    .y_out   (y_out)
  );

  always #5 aclk = ~aclk;

  // Rising-edge counter used to time-stamp expected completions.
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  exp_t e_mon;
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && done === 1'b1) begin
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        chk("y_out", {16'h0000, y_out}, {16'h0000, e_mon.y});
        chk("done_cycle", cyc, e_mon.at);
      end
    end
  end

  // One-cycle start pulse; the expectation is due 16 edges after the start edge.
  task automatic drive_start(input logic [15:0] x, input logic [15:0] y, input bit push);
    @(negedge aclk);
    start = 1'b1;
    x_in  = x;
    if (push) exp_q.push_back('{y: y, at: cyc + 17});
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge aclk);
      n++;
    end
    chk(tag, exp_q.size(), 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    aresetn = 1'b0;
    start   = 1'b0;
    x_in    = 16'h0000;
    #1;
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_y_out", {16'h0000, y_out}, 32'h0000_0000);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // V1: zero operand gives 1.0
    drive_start(16'h0000, 16'h8000, 1'b1);
    chk("v1_busy", {31'd0, busy}, 32'd1);
    wait_idle("v1_idle", 40);

    // V2: single-bit operands hit the ROM entries directly
    drive_start(16'h1000, 16'h2F16, 1'b1);
    wait_idle("v2a_idle", 40);
    drive_start(16'h0800, 16'h4DA2, 1'b1);
    chk("v2_y_hold", {16'h0000, y_out}, 32'h0000_2F16);
    wait_idle("v2b_idle", 40);
    drive_start(16'h2000, 16'h1152, 1'b1);
    wait_idle("v2c_idle", 40);

    // V3: largest operand underflows to zero; busy spans 16 cycles
    drive_start(16'hFFFF, 16'h0000, 1'b1);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) nb++;
      @(negedge aclk);
    end
    chk("v3_busy_cycles", nb, 32'd16);
    wait_idle("v3_idle", 5);

    // V4: start and operand changes during RUN are ignored
    drive_start(16'h1000, 16'h2F16, 1'b1);
    repeat (4) @(negedge aclk);
    start = 1'b1;
    x_in  = 16'h0000;
    @(negedge aclk);
    start = 1'b0;
    chk("v4_busy", {31'd0, busy}, 32'd1);
    wait_idle("v4_idle", 40);
    repeat (20) @(negedge aclk);
    chk("v4_y_out", {16'h0000, y_out}, 32'h0000_2F16);

    // V5: start held high restarts every 17 cycles
    @(negedge aclk);
    start = 1'b1;
    x_in  = 16'h2000;
    exp_q.push_back('{y: 16'h1152, at: cyc + 17});
    exp_q.push_back('{y: 16'h1152, at: cyc + 34});
    exp_q.push_back('{y: 16'h1152, at: cyc + 51});
    for (int i = 0; i <= 50; i++) begin
      @(negedge aclk);
      if (i == 16 || i == 33) chk("v5_busy_gap", {31'd0, busy}, 32'd0);
      if (i == 17 || i == 34) chk("v5_busy_restart", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    wait_idle("v5_idle", 5);
    repeat (20) @(negedge aclk);
    chk("v5_no_extra_run", {31'd0, busy}, 32'd0);

    // V6: reset mid-run aborts without a done pulse
    drive_start(16'h1000, 16'h2F16, 1'b0);
    repeat (7) @(negedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    chk("v6_busy",  {31'd0, busy}, 32'd0);
    chk("v6_done",  {31'd0, done}, 32'd0);
    chk("v6_y_out", {16'h0000, y_out}, 32'h0000_0000);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (20) @(negedge aclk);
    chk("v6_y_after_rst", {16'h0000, y_out}, 32'h0000_0000);
    chk("v6_busy_after_rst", {31'd0, busy}, 32'd0);
    drive_start(16'h1000, 16'h2F16, 1'b1);
    wait_idle("v6_idle", 40);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
